ex_result_arb: RTL and testbench
================================

// Module: ex_result_arb
// PURPOSE
//  EX-stage result collector: N producers (ALU, FP-ALU, CSR, MUL/DIV, ...) each offer a
//  tagged result under valid/ready. Block grants one per cycle, queues winner in a 2-entry
//  buffer, presents it to MEM/WB via valid/ready. Replaces static EX result mux; supports multi-cycle units and WB back-pressure.
// PARAMETERS
//  NSRC   4   number of result producers (2..8)
//  XLEN   32  result data width
//  TAGW   5   destination register index width
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous reset, active low
//  flush      in   1          drop all queued/offered results (branch/trap)
//  src_valid  in   NSRC       producer i has a result
//  src_data   in   NSRC*XLEN  producer i result, slice [i*XLEN +: XLEN]
//  src_rd     in   NSRC*TAGW  producer i destination, slice [i*TAGW +: TAGW]
//  src_ready  out  NSRC       one-hot grant: producer i's result accepted this cycle
//  out_valid  out  1          head entry valid
//  out_ready  in   1          MEM/WB consumes head
//  out_data   out  XLEN       head result
//  out_rd     out  TAGW       head destination
//  out_we     out  1          out_valid & (out_rd != 0)
//  out_src    out  $clog2(NSRC) index of producer of head
// BEHAVIOUR
//  - Reset (async, rst_n=0): count=0, out_valid=0, out_data=0, out_rd=0, out_src=0, RR ptr=0.
//  - Buffer: 2-entry FIFO, count 0..2. can_accept = (count<2) & ~flush (registered count only;
//    no combinational path out_ready->src_ready).
//  - Grant: among src_valid, fixed priority, lowest index wins. src_ready[i]=grant[i]&can_accept;
//    at most one bit set. Losers hold valid/data stable until granted.
//  - Push on any src_ready bit; pop on out_valid&out_ready. Push+pop same cycle: count unchanged,
//    order preserved. Push at count==1 with pop: new entry becomes head next cycle.
//  - Latency: granted result visible on out_* next cycle when buffer empty (1 cycle).
//  - count==2: src_ready=0 for all; full throughput (1/cycle) sustained at count<=1 with out_ready=1.
//  - out_* registered; out_data/out_rd/out_src hold last value when out_valid=0.
//  - flush: no grant that cycle; next cycle count=0, out_valid=0; pop ignored during flush.
//  - Reset mid-operation: queued entries lost, outputs as reset values immediately.
//  - NSRC not power of 2: out_src width $clog2(NSRC); unused codes never produced.
// CONFIGURATION
//  EX_RR_ARB_EN defined: round-robin grant; search starts at ptr, ptr <= granted index+1
//    (mod NSRC) after each accepted push; ptr unchanged when no push; flush does not move ptr.
//  Undefined: fixed priority as above, no ptr register.
// STRUCTURE
//  - ex_pkg: EX_NSRC default, src index constants SRC_ALU=0, SRC_FPU=1, SRC_CSR=2, SRC_MDU=3,
//    typedef ex_res_t {data XLEN, rd TAGW, src}.
//  - Sub-module ex_res_fifo2: 2-entry FIFO of ex_res_t with push/pop/flush/count; arbiter in top.
// TESTING
//  1 Single: src_valid=4'b0001, data=0x1234_5678, rd=3, out_ready=1 -> src_ready=0001 cycle 0;
//    out_valid=1, out_data=0x12345678, out_rd=3, out_we=1, out_src=0 cycle 1.
//  2 Conflict (fixed): src_valid=1010 -> src_ready=0010, then 1000; out_src 1 then 3.
//  3 Back-pressure: out_ready=0, 3 results offered -> two accepted, count=2, src_ready=0;
//    out_ready=1 -> drains in order, third accepted cycle after first pop.
//  4 Flush with count=2 and src_valid=0001 -> no grant; next cycle out_valid=0, count=0.
//  5 rd=0 result 0xDEAD -> out_valid=1, out_we=0.
//  6 EX_RR_ARB_EN: all four valid every cycle, out_ready=1 -> grants 0,1,2,3,0 in order.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared EX-stage result types and producer index constants.
// The optional round-robin grant in ex_result_arb is selected by defining EX_RR_ARB_EN.
package ex_pkg;

    localparam int EX_NSRC = 4;
    localparam int EX_XLEN = 32;
    localparam int EX_TAGW = 5;
    localparam int EX_SRCW = $clog2(EX_NSRC);

    localparam logic [EX_SRCW-1:0] SRC_ALU = 2'd0;
    localparam logic [EX_SRCW-1:0] SRC_FPU = 2'd1;
    localparam logic [EX_SRCW-1:0] SRC_CSR = 2'd2;
    localparam logic [EX_SRCW-1:0] SRC_MDU = 2'd3;

    typedef struct packed {
        logic [EX_XLEN-1:0] data;
        logic [EX_TAGW-1:0] rd;
        logic [EX_SRCW-1:0] src;
    } ex_res_t;

endpackage

// File: rtl/ex_res_fifo2.sv
// Two-entry result FIFO. The head entry is held in its own register so that it
// drives the consumer directly; the head keeps its last value once drained.
module ex_res_fifo2
    import ex_pkg::*;
#(
    parameter type T = ex_res_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  T           din,
    input  logic       pop,
    output T           head,
    output logic       head_valid,
    output logic [1:0] count
);

    T           head_r;
    T           tail_r;
    logic [1:0] count_r;
    logic       valid_r;

    T           head_nxt_s;
    T           tail_nxt_s;
    logic [1:0] count_nxt_s;
    logic       pop_s;

    assign pop_s      = pop & (count_r != 2'd0);
    assign head       = head_r;
    assign head_valid = valid_r;
    assign count      = count_r;

    // Next-state for head/tail/count; push and pop together keep the count and the order.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({push, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_nxt_s = din;
                    end else begin
                        tail_nxt_s = din;
                    end
                    count_nxt_s = count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_nxt_s = tail_r;
                    end else begin
                        head_nxt_s = head_r;
                    end
                    count_nxt_s = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        head_nxt_s = tail_r;
                        tail_nxt_s = din;
                    end else begin
                        head_nxt_s = din;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
        end
    end

endmodule

// File: rtl/ex_result_arb.sv
// EX-stage result collector: grants one producer per cycle into a 2-entry FIFO.
// Define EX_RR_ARB_EN for round-robin grant; otherwise lowest index wins.
module ex_result_arb
    import ex_pkg::*;
#(
    parameter int NSRC = EX_NSRC,
    parameter int XLEN = EX_XLEN,
    parameter int TAGW = EX_TAGW,
    localparam int SRCW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [NSRC*TAGW-1:0] src_rd,
    output logic [NSRC-1:0]      src_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic [TAGW-1:0]      out_rd,
    output logic                 out_we,
    output logic [SRCW-1:0]      out_src
);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [TAGW-1:0] rd;
        logic [SRCW-1:0] src;
    } res_t;

    res_t            push_res_s;
    res_t            head_s;
    logic [1:0]      count_s;
    logic            can_accept_s;
    logic            gnt_any_s;
    logic [SRCW-1:0] gnt_idx_s;
    logic            push_s;
    logic            pop_s;

    // Accept decision uses only registered occupancy, never out_ready.
    assign can_accept_s = (count_s != 2'd2) & ~flush;
    assign gnt_any_s    = |src_valid;
    assign push_s       = can_accept_s & gnt_any_s;
    assign pop_s        = out_valid & out_ready & ~flush;

`ifdef EX_RR_ARB_EN
    logic [SRCW-1:0] ptr_r;

    function automatic logic [SRCW-1:0] rr_idx(input logic [SRCW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= NSRC) ? SRCW'(sum - NSRC) : SRCW'(sum);
    endfunction

    // Walk from the far end back to ptr so the first valid at/after ptr wins.
    always_comb begin
        gnt_idx_s = {SRCW{1'b0}};
        for (int k = NSRC - 1; k >= 0; k--) begin
            gnt_idx_s = src_valid[rr_idx(ptr_r, k)] ? rr_idx(ptr_r, k) : gnt_idx_s;
        end
    end

    // Pointer advances past the winner only when a result is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {SRCW{1'b0}};
        end else if (push_s) begin
            ptr_r <= (int'(gnt_idx_s) == NSRC - 1) ? {SRCW{1'b0}} : gnt_idx_s + SRCW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: walking downwards leaves the lowest valid index selected.
    always_comb begin
        gnt_idx_s = {SRCW{1'b0}};
        for (int k = NSRC - 1; k >= 0; k--) begin
            gnt_idx_s = src_valid[k] ? SRCW'(k) : gnt_idx_s;
        end
    end
`endif

    // One-hot ready and the entry to enqueue for the winning producer.
    always_comb begin
        src_ready       = push_s ? ({{(NSRC-1){1'b0}}, 1'b1} << gnt_idx_s) : {NSRC{1'b0}};
        push_res_s.data = src_data[int'(gnt_idx_s)*XLEN +: XLEN];
        push_res_s.rd   = src_rd[int'(gnt_idx_s)*TAGW +: TAGW];
        push_res_s.src  = gnt_idx_s;
    end

    ex_res_fifo2 #(
        .T(res_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push_s),
        .din        (push_res_s),
        .pop        (pop_s),
        .head       (head_s),
        .head_valid (out_valid),
        .count      (count_s)
    );

    assign out_data = head_s.data;
    assign out_rd   = head_s.rd;
    assign out_src  = head_s.src;
    assign out_we   = out_valid & (head_s.rd != {TAGW{1'b0}});

endmodule

// File: tb/tb_ex_result_arb.sv
// Scoreboard bench for ex_result_arb: stimulus pushes expected results, a
// negedge monitor pops and compares on every consumed output.
module tb_ex_result_arb;

    localparam int NSRC = 4;
    localparam int XLEN = 32;
    localparam int TAGW = 5;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  src;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC*XLEN-1:0] src_data;
    logic [NSRC*TAGW-1:0] src_rd;
    logic [NSRC-1:0]      src_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_data;
    logic [TAGW-1:0]      out_rd;
    logic                 out_we;
    logic [1:0]           out_src;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    ex_result_arb #(.NSRC(NSRC), .XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_rd    (src_rd),
        .src_ready (src_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input logic [31:0] d, input logic [4:0] r);
        src_valid[i]           = 1'b1;
        src_data[i*XLEN +: XLEN] = d;
        src_rd[i*TAGW +: TAGW]   = r;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [4:0] r, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.rd   = r;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got data 0x%0h, expected no output", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(mon_e.data));
                chk("out_rd", 64'(out_rd), 64'(mon_e.rd));
                chk("out_src", 64'(out_src), 64'(mon_e.src));
                chk("out_we", 64'(out_we), 64'(mon_e.rd != 5'd0));
            end
        end
    end

    initial begin
        int g[5];
        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = 4'b0000;
        src_data  = '0;
        src_rd    = '0;
        out_ready = 1'b0;
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_rd", 64'(out_rd), 64'd0);
        chk("reset_out_src", 64'(out_src), 64'd0);
        chk("reset_src_ready", 64'(src_ready), 64'd0);
        rst_n = 1'b1;
        step();

        // single result, one-cycle latency
        out_ready = 1'b1;
        offer(0, 32'h1234_5678, 5'd3);
        #1 chk("t1_ready", 64'(src_ready), 64'h1);
        push_exp(32'h1234_5678, 5'd3, 2'd0);
        step();
        src_valid = 4'b0000;
        #1 chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_we", 64'(out_we), 64'd1);
        step();

        // fixed-priority conflict
        offer(1, 32'h1111_0001, 5'd5);
        offer(3, 32'h3333_0003, 5'd7);
        #1 chk("t2_ready_a", 64'(src_ready), 64'h2);
        push_exp(32'h1111_0001, 5'd5, 2'd1);
        step();
        src_valid[1] = 1'b0;
        #1 chk("t2_ready_b", 64'(src_ready), 64'h8);
        push_exp(32'h3333_0003, 5'd7, 2'd3);
        step();
        src_valid = 4'b0000;
        step();
        step();

        // back-pressure: two accepted, third waits for the first pop
        out_ready = 1'b0;
        offer(0, 32'hAAAA_0000, 5'd1);
        offer(1, 32'hBBBB_0001, 5'd2);
        offer(2, 32'hCCCC_0002, 5'd4);
        #1 chk("t3_ready_a", 64'(src_ready), 64'h1);
        push_exp(32'hAAAA_0000, 5'd1, 2'd0);
        step();
        src_valid[0] = 1'b0;
        #1 chk("t3_ready_b", 64'(src_ready), 64'h2);
        push_exp(32'hBBBB_0001, 5'd2, 2'd1);
        step();
        src_valid[1] = 1'b0;
        #1 chk("t3_full_ready", 64'(src_ready), 64'h0);
        chk("t3_full_valid", 64'(out_valid), 64'd1);
        step();
        out_ready = 1'b1;
        #1 chk("t3_full_ready2", 64'(src_ready), 64'h0);
        step();
        #1 chk("t3_ready_c", 64'(src_ready), 64'h4);
        push_exp(32'hCCCC_0002, 5'd4, 2'd2);
        step();
        src_valid = 4'b0000;
        step();
        step();
        step();

        // flush with a full buffer and a pending offer
        out_ready = 1'b0;
        offer(0, 32'hD000_0000, 5'd6);
        step();
        src_valid[0] = 1'b0;
        offer(1, 32'hE000_0001, 5'd8);
        step();
        src_valid[1] = 1'b0;
        offer(0, 32'hF000_0000, 5'd9);
        flush = 1'b1;
        #1 chk("t4_flush_ready", 64'(src_ready), 64'h0);
        step();
        flush     = 1'b0;
        src_valid = 4'b0000;
        #1 chk("t4_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        offer(3, 32'h6000_0003, 5'd9);
        #1 chk("t4_ready_after", 64'(src_ready), 64'h8);
        push_exp(32'h6000_0003, 5'd9, 2'd3);
        step();
        src_valid = 4'b0000;
        #1 chk("t4_new_head", 64'(out_data), 64'h6000_0003);
        step();
        step();

        // rd = 0 suppresses the write enable
        offer(2, 32'h0000_DEAD, 5'd0);
        #1 chk("t5_ready", 64'(src_ready), 64'h4);
        push_exp(32'h0000_DEAD, 5'd0, 2'd2);
        step();
        src_valid = 4'b0000;
        #1 chk("t5_out_valid", 64'(out_valid), 64'd1);
        chk("t5_out_we", 64'(out_we), 64'd0);
        step();
        step();

        // reset while an entry is queued
        out_ready = 1'b0;
        offer(1, 32'h5555_5555, 5'd1);
        step();
        src_valid = 4'b0000;
        #1 chk("rst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1 chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_data", 64'(out_data), 64'd0);
        chk("rst_mid_src", 64'(out_src), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // all producers valid every cycle at full throughput
`ifdef EX_RR_ARB_EN
        g = '{0, 1, 2, 3, 0};
`else
        g = '{0, 0, 0, 0, 0};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            offer(i, 32'h0000_00A0 + 32'(i), 5'(10 + i));
        end
        for (int c = 0; c < 5; c++) begin
            #1 chk("t6_grant", 64'(src_ready), 64'(1) << g[c]);
            push_exp(32'h0000_00A0 + 32'(g[c]), 5'(10 + g[c]), 2'(g[c]));
            step();
        end
        src_valid = 4'b0000;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
